// File: rtl/etc1_block_stream.sv
// etc1_block_stream: streaming ETC1 block decoder.
// Takes one 64-bit compressed block per handshake and emits its 16 texels
// in raster order, LANES texels per beat, with no bubble between blocks.
module etc1_block_stream #(
    parameter int LANES      = 1,
    parameter int COLOR_BITS = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [63:0]                     in_block,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*3*COLOR_BITS-1:0]   out_pixels,
    output logic [3:0]                      out_index,
    output logic                            out_last
);

    localparam int BEATS = 16 / LANES;
    localparam int PIXW  = 3 * COLOR_BITS;
    localparam logic [3:0] LAST_K = 4'(BEATS - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [63:0]             block_q, block_d;
    logic [3:0]              k_q, k_d;
    logic [LANES*PIXW-1:0]   pixels_q, pixels_d;
    logic                    load;
    logic                    lastBeat;
    logic [23:0]             texel;

    // Modifier magnitude for a codeword: 'a' for lsb=0, 'b' for lsb=1.
    function automatic logic [7:0] modMag(input logic [2:0] cw, input logic useB);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'd0;
        b = 8'd0;
        case (cw)
            3'd0: begin a = 8'd2;  b = 8'd8;   end
            3'd1: begin a = 8'd5;  b = 8'd17;  end
            3'd2: begin a = 8'd9;  b = 8'd29;  end
            3'd3: begin a = 8'd13; b = 8'd42;  end
            3'd4: begin a = 8'd18; b = 8'd60;  end
            3'd5: begin a = 8'd24; b = 8'd80;  end
            3'd6: begin a = 8'd33; b = 8'd106; end
            3'd7: begin a = 8'd47; b = 8'd183; end
            default: begin a = 8'd0; b = 8'd0; end
        endcase
        return useB ? b : a;
    endfunction

    // 8-bit base colour of one channel; chByte holds that channel's byte of
    // the control word (4+4 individual, or 5-bit base + 3-bit signed delta).
    function automatic logic [7:0] channelBase(input logic [7:0] chByte,
                                               input logic diff,
                                               input logic sub);
        logic [4:0] b0;
        logic [4:0] b1;
        logic [4:0] v5;
        logic [3:0] v4;
        logic [7:0] result;
        b0 = chByte[7:3];
        b1 = b0 + {{2{chByte[2]}}, chByte[2:0]};
        v5 = sub ? b1 : b0;
        v4 = sub ? chByte[3:0] : chByte[7:4];
        if (diff) begin
            result = {v5, v5[4:2]};
        end else begin
            result = {v4, v4};
        end
        return result;
    endfunction

    // Signed add of the modifier, clamped into 0..255.
    function automatic logic [7:0] applyModifier(input logic [7:0] base,
                                                 input logic [7:0] mag,
                                                 input logic negate);
        logic signed [9:0] sum;
        if (negate) begin
            sum = $signed({2'b00, base}) - $signed({2'b00, mag});
        end else begin
            sum = $signed({2'b00, base}) + $signed({2'b00, mag});
        end
        if (sum < 10'sd0) begin
            return 8'h00;
        end else if (sum > 10'sd255) begin
            return 8'hFF;
        end
        return sum[7:0];
    endfunction

    // Full 8-bit {R,G,B} for raster texel p = 4*y+x of a block.
    function automatic logic [23:0] decodeTexel(input logic [63:0] blk, input logic [3:0] p);
        logic [1:0] x;
        logic [1:0] y;
        logic [3:0] i;
        logic       sub;
        logic       msb;
        logic       lsb;
        logic [2:0] cw;
        logic [7:0] mag;
        logic [7:0] rCh;
        logic [7:0] gCh;
        logic [7:0] bCh;
        x   = p[1:0];
        y   = p[3:2];
        sub = blk[32] ? y[1] : x[1];
        i   = {x, y};
        msb = blk[{2'b01, i}];
        lsb = blk[{2'b00, i}];
        cw  = sub ? blk[36:34] : blk[39:37];
        mag = modMag(cw, lsb);
        rCh = applyModifier(channelBase(blk[63:56], blk[33], sub), mag, msb);
        gCh = applyModifier(channelBase(blk[55:48], blk[33], sub), mag, msb);
        bCh = applyModifier(channelBase(blk[47:40], blk[33], sub), mag, msb);
        return {rCh, gCh, bCh};
    endfunction

    assign lastBeat   = (state_q == EMIT) && (k_q == LAST_K);
    assign in_ready   = (state_q == IDLE) || (lastBeat && out_ready);
    assign out_valid  = (state_q == EMIT);
    assign out_last   = lastBeat;
    assign out_index  = 4'(int'(k_q) * LANES);
    assign out_pixels = pixels_q;

    // Next-state logic: accept a block when idle or on the consumed final beat,
    // otherwise step the beat counter whenever the consumer takes a beat.
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        k_d     = k_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    block_d = in_block;
                    k_d     = 4'd0;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (lastBeat) begin
                        if (in_valid) begin
                            block_d = in_block;
                            k_d     = 4'd0;
                            load    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        k_d  = k_q + 4'd1;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the beat that will be presented next cycle, truncated per channel.
    always_comb begin
        pixels_d = '0;
        texel    = '0;
        for (int l = 0; l < LANES; l++) begin
            texel = decodeTexel(block_d, 4'(int'(k_d) * LANES + l));
            pixels_d[l*PIXW +: PIXW] = {texel[23 -: COLOR_BITS],
                                        texel[15 -: COLOR_BITS],
                                        texel[7  -: COLOR_BITS]};
        end
    end

    // State, held block, beat counter and registered output beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            block_q  <= '0;
            k_q      <= '0;
            pixels_q <= '0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            k_q     <= k_d;
            if (load) begin
                pixels_q <= pixels_d;
            end
        end
    end

endmodule

// File: tb/tb_etc1_block_stream.sv
// tb_etc1_block_stream: directed self-checking bench for etc1_block_stream.
// Three instances cover LANES=1, LANES=4 and LANES=16 (4-bit colour).
module tb_etc1_block_stream;

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO  = 64'h0;
    // diff=1 flip=0, R0=0 dR=-4, G/B base 0 delta 0, cw0=0 cw1=7
    localparam logic [63:0] DIFFP = 64'h0400_001E_0000_FFFF;
    localparam logic [63:0] DIFFN = 64'h0400_001E_FFFF_0000;

    logic clk;
    logic reset;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [63:0]  a_in_block;
    logic [23:0]  a_out_pixels;
    logic [3:0]   a_out_index;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [63:0]  b_in_block;
    logic [95:0]  b_out_pixels;
    logic [3:0]   b_out_index;

    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [63:0]  c_in_block;
    logic [191:0] c_out_pixels;
    logic [3:0]   c_out_index;

    int assertCount = 0;
    int failCount   = 0;

    etc1_block_stream #(.LANES(1), .COLOR_BITS(8)) dutA (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_block(a_in_block),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pixels(a_out_pixels),
        .out_index(a_out_index), .out_last(a_out_last)
    );

    etc1_block_stream #(.LANES(4), .COLOR_BITS(8)) dutB (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pixels(b_out_pixels),
        .out_index(b_out_index), .out_last(b_out_last)
    );

    etc1_block_stream #(.LANES(16), .COLOR_BITS(4)) dutC (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_block(c_in_block),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_pixels(c_out_pixels),
        .out_index(c_out_index), .out_last(c_out_last)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Hand-computed 24-bit texels for the LANES=1 instance.
    function automatic logic [31:0] expA(input int mode, input int p);
        case (mode)
            0:       return (p < 8) ? 32'h484848 : 32'h404040;
            1:       return ((p % 4) < 2) ? 32'h080808 : 32'hFFB7B7;
            2:       return ((p % 4) < 2) ? 32'h000000 : 32'hB80000;
            default: return 32'h020202;
        endcase
    endfunction

    // Hand-computed 12-bit texels for the 4-bit colour LANES=16 instance.
    function automatic logic [31:0] expC(input int sel, input int p);
        if (sel == 0) begin
            return ((p % 4) < 2) ? 32'h000 : 32'hFBB;
        end
        return 32'h444;
    endfunction

    // Offer one block to instance A; returns just after the accepting edge.
    task automatic applyStimulus(input logic [63:0] blk);
        a_in_block = blk;
        a_in_valid = 1'b1;
        #1;
        checkOutput("A in_ready at accept", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    // Drain 16 beats from instance A using a repeating 4-cycle out_ready pattern.
    task automatic consumeA(input int mode, input logic [3:0] readyPattern);
        int beat   = 0;
        int cycles = 0;
        while (beat < 16 && cycles < 200) begin
            a_out_ready = readyPattern[cycles % 4];
            #1;
            if (a_out_valid !== 1'b1) begin
                checkOutput($sformatf("A out_valid beat %0d", beat), 32'(a_out_valid), 32'd1);
                cycles = 200;
            end else begin
                checkOutput($sformatf("A out_index beat %0d", beat), 32'(a_out_index), 32'(beat));
                checkOutput($sformatf("A out_last beat %0d", beat), 32'(a_out_last), 32'(beat == 15));
                checkOutput($sformatf("A pixel m%0d beat %0d", mode, beat), 32'(a_out_pixels), expA(mode, beat));
                if (a_out_ready) begin
                    beat++;
                end
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        checkOutput("A beats delivered", 32'(beat), 32'd16);
        a_out_ready = 1'b1;
        #1;
        checkOutput("A idle out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("A idle in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_in_valid = 1'b0; a_in_block = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_block = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_block = '0; c_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset A out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("reset A out_index", 32'(a_out_index), 32'd0);
        checkOutput("reset A out_last", 32'(a_out_last), 32'd0);
        checkOutput("reset A out_pixels", 32'(a_out_pixels), 32'd0);
        checkOutput("reset B out_valid", 32'(b_out_valid), 32'd0);
        checkOutput("reset C out_valid", 32'(c_out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release A in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("release B in_ready", 32'(b_in_ready), 32'd1);
        checkOutput("release C in_ready", 32'(c_in_ready), 32'd1);

        // All-ones block, consumer always ready
        applyStimulus(ONES);
        consumeA(0, 4'b1111);

        // All-ones block with out_ready pattern 1,0,0,1
        applyStimulus(ONES);
        consumeA(0, 4'b1001);

        // Differential wrap R0=0, dR=-4, upper clamp and lower clamp
        applyStimulus(DIFFP);
        consumeA(1, 4'b1111);
        applyStimulus(DIFFN);
        consumeA(2, 4'b1111);

        // LANES=4 all-zero block
        b_in_block  = ZERO;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        #1;
        checkOutput("B in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        #1;
        checkOutput("B latency out_valid", 32'(b_out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("B out_valid beat %0d", k), 32'(b_out_valid), 32'd1);
            checkOutput($sformatf("B out_index beat %0d", k), 32'(b_out_index), 32'(4 * k));
            checkOutput($sformatf("B out_last beat %0d", k), 32'(b_out_last), 32'(k == 3));
            for (int l = 0; l < 4; l++) begin
                checkOutput($sformatf("B lane %0d beat %0d", l, k), 32'(b_out_pixels[l*24 +: 24]), 32'h020202);
            end
            @(posedge clk);
            #2;
        end
        checkOutput("B idle out_valid", 32'(b_out_valid), 32'd0);

        // LANES=16 back-to-back blocks, no bubble
        @(posedge clk);
        #1;
        c_in_block  = DIFFP;
        c_in_valid  = 1'b1;
        c_out_ready = 1'b1;
        #1;
        checkOutput("C in_ready idle", 32'(c_in_ready), 32'd1);
        @(posedge clk);
        #1;
        c_in_block = ONES;
        #1;
        checkOutput("C blk0 out_valid", 32'(c_out_valid), 32'd1);
        checkOutput("C blk0 out_last", 32'(c_out_last), 32'd1);
        checkOutput("C blk0 out_index", 32'(c_out_index), 32'd0);
        checkOutput("C blk0 in_ready", 32'(c_in_ready), 32'd1);
        for (int p = 0; p < 16; p++) begin
            checkOutput($sformatf("C blk0 lane %0d", p), 32'(c_out_pixels[p*12 +: 12]), expC(0, p));
        end
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        #1;
        checkOutput("C blk1 out_valid", 32'(c_out_valid), 32'd1);
        checkOutput("C blk1 out_last", 32'(c_out_last), 32'd1);
        checkOutput("C blk1 in_ready", 32'(c_in_ready), 32'd1);
        for (int p = 0; p < 16; p++) begin
            checkOutput($sformatf("C blk1 lane %0d", p), 32'(c_out_pixels[p*12 +: 12]), expC(1, p));
        end
        @(posedge clk);
        #2;
        checkOutput("C idle out_valid", 32'(c_out_valid), 32'd0);

        // Reset asserted mid-block at k=2 on instance A
        @(posedge clk);
        #1;
        applyStimulus(ONES);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("A pre-reset out_index", 32'(a_out_index), 32'd2);
        reset = 1'b0;
        #1;
        checkOutput("A mid reset out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("A mid reset out_index", 32'(a_out_index), 32'd0);
        checkOutput("A mid reset out_last", 32'(a_out_last), 32'd0);
        checkOutput("A mid reset out_pixels", 32'(a_out_pixels), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("A post-reset in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(ZERO);
        consumeA(3, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/etc1_block_stream.md
Name: etc1_block_stream

Overview:
Streaming ETC1 block decoder. It accepts one 64-bit compressed block per valid/ready handshake and emits all 16 texels of the 4x4 block in raster order, LANES texels per output beat. It sits between the compressed-frame fetch and the LED pixel formatter. It supersedes per-texel random-access decode with a zero-bubble, back-pressured pipeline and configurable colour depth.

Parameters:
LANES, 1, texels per output beat; legal values 1, 2, 4, 8, 16; beats per block = 16/LANES.
COLOR_BITS, 8, output bits per channel (1..8). Each channel is the 8-bit decoded value truncated to its top COLOR_BITS bits.

Ports:
clk  in  1  clock, all logic rising-edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  in  1  in_block is valid.
in_ready  out  1  block accepted when in_valid & in_ready.
in_block  in  64  ETC1 block; [63:32] colour/control word, [31:0] texel indices.
out_valid  out  1  output beat valid.
out_ready  in  1  beat consumed when out_valid & out_ready.
out_pixels  out  LANES*3*COLOR_BITS  lane l at [l*3*COLOR_BITS +: 3*COLOR_BITS], packed {R,G,B} with R in the MSBs.
out_index  out  4  raster index (4*y+x) of lane 0.
out_last  out  1  high on the final beat of a block.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_last=0, out_index=0, out_pixels=0, in_ready=1 once reset releases. Any held block is discarded. Reset in mid-block drops the remaining beats silently.
- State: IDLE (no block held) and EMIT (block held, beat counter k = 0..16/LANES-1).
- IDLE: in_ready=1. On accept, latch the block, set k=0, go to EMIT. out_valid rises in the next cycle, so latency is 1 cycle from accept to first beat.
- EMIT: out_valid=1. If out_ready, advance k. On the last beat (out_last=1):
  - if in_valid, accept the new block in the same cycle and restart with k=0 (no bubble);
  - otherwise return to IDLE.
- in_ready = IDLE | (EMIT & out_last & out_ready). This is combinational from state and out_ready, not from in_valid.
- While out_valid & !out_ready, out_pixels, out_index and out_last hold stable.
- Beat k, lane l covers texel p = k*LANES+l, with x = p%4 and y = p/4. out_index = k*LANES.
- Decode rules:
  - diff = bit 33, flip = bit 32, cw0 = [39:37], cw1 = [36:34].
  - Individual mode (diff=0): 4-bit bases R0=[63:60], R1=[59:56], G0=[55:52], G1=[51:48], B0=[47:44], B1=[43:40]. Expand each as {v,v}.
  - Differential mode (diff=1): 5-bit bases R0=[63:59], G0=[55:51], B0=[47:43]. Signed 3-bit deltas at [58:56], [50:48], [42:40]. Base1 = (base0 + delta) mod 32; out-of-range sums wrap and are not flagged. Expand 5-bit v as {v, v[4:2]}.
  - Sub-block selection: flip=0 uses sub-block 0 when x<2; flip=1 uses sub-block 0 when y<2.
  - Texel index bits: i = 4*x+y; msb = bit 16+i, lsb = bit i.
  - Modifier table (a,b) for cw 0..7: (2,8), (5,17), (9,29), (13,42), (18,60), (24,80), (33,106), (47,183).
  - Index code {msb,lsb}: 00 -> +a, 01 -> +b, 10 -> -a, 11 -> -b.
  - Per channel: signed base+mod, clamped to 0..255, then truncated to COLOR_BITS.
- Output is registered. Combinational decode happens from the held block and k only.

Test Plan:
- All-ones block 64'hffffffffffffffff, LANES=1, out_ready=1 -> 16 beats, out_index 0..15, out_last only on beat 15. Texels at indices 0..7 = 24'h484848; indices 8..15 = 24'h404040.
- All-zero block, LANES=4 -> 4 beats, every lane 24'h020202, out_last on beat 3, first out_valid exactly 1 cycle after accept.
- Two blocks presented back-to-back with out_ready=1, LANES=16 -> out_valid stays high 2 consecutive cycles, in_ready=1 in both cycles, no bubble.
- out_ready toggling 1,0,0,1 during the all-ones block -> stalled beats held bit-stable, no beat lost or duplicated, 16 total.
- Differential wrap: R0=5'd0, dR=3'b100 (-4) -> R1 base = 28 -> expanded 8'hE7. Check sub-block-1 texels against the clamp rule.
- reset driven low while at k=2 -> out_valid=0 immediately (async). After release, in_ready=1 and the next accepted block starts at out_index 0.
